// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// PC increment and the default reset fetch address.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = XLEN'(0);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        READY   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues instruction-memory requests, buffers the
// returned word and presents it to the IF register, redirecting on branches.
// Optional feature: define IF_FETCH_BYPASS_EN to forward a zero-wait memory
// response straight to the outputs for one instruction per cycle.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instruction_out,
    output logic            stall_out
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] target_pc_q, target_pc_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] pc_next;

    // Sequential PC, wraps modulo 2^32
    assign pc_next = fetch_pc_q + PC_STEP;

    // State and datapath registers, asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            target_pc_q <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            target_pc_q <= target_pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    // Next-state, register updates and outputs
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        target_pc_d     = target_pc_q;
        buf_pc_d        = buf_pc_q;
        buf_instr_d     = buf_instr_q;
        imem_req        = 1'b0;
        imem_addr       = fetch_pc_q;
        stall_out       = 1'b1;
        pc_out          = buf_pc_q;
        instruction_out = buf_instr_q;

        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (branch_taken) begin
                        // Redirect wins; the returned word is stale
                        fetch_pc_d = branch_addr;
                    end else begin
                        buf_pc_d    = pc_next;
                        buf_instr_d = imem_rdata;
                        fetch_pc_d  = pc_next;
`ifdef IF_FETCH_BYPASS_EN
                        if (!freeze) begin
                            pc_out          = pc_next;
                            instruction_out = imem_rdata;
                            stall_out       = 1'b0;
                        end else begin
                            state_d = READY;
                        end
`else
                        state_d = READY;
`endif
                    end
                end else if (branch_taken) begin
                    // Request cannot be aborted; wait for it and drop the data
                    target_pc_d = branch_addr;
                    state_d     = DISCARD;
                end
            end

            DISCARD: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetch_pc_d = branch_taken ? branch_addr : target_pc_q;
                    state_d    = FETCH;
                end else if (branch_taken) begin
                    target_pc_d = branch_addr;
                end
            end

            READY: begin
                stall_out = 1'b0;
                if (branch_taken) begin
                    fetch_pc_d = branch_addr;
                    state_d    = FETCH;
                end else if (!freeze) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // No request and no valid instruction while reset is held
        if (rst) begin
            imem_req        = 1'b0;
            stall_out       = 1'b1;
            pc_out          = '0;
            instruction_out = '0;
        end
    end

endmodule
